// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
//
// Sequential AES-128 key schedule. A 128-bit cipher key is accepted over a
// valid/ready handshake. Round keys 0..NUM_ROUNDS are then emitted one per
// output handshake, each tagged with its round index. Only the current round
// key is held; the next one is derived combinationally from it and the
// running round constant.
//
// Ports
//   clk              in   system clock, rising-edge active
//   reset            in   synchronous active-high reset
//   key_valid_in     in   key_in carries a new cipher key
//   key_in           in   cipher key, bits [127:120] are byte 0
//   key_ready        out  high in IDLE, key accepted on valid && ready edge
//   round_key        out  current round key, stable while stalled
//   round_key_valid  out  round_key / round_idx valid
//   round_key_ready  in   consumer takes round_key on valid && ready edge
//   round_idx        out  index 0..NUM_ROUNDS of the key on round_key
//   busy             out  high while a key sequence is in progress
//   done             out  one-cycle pulse after the last round key is taken
// -----------------------------------------------------------------------------
module aes_key_expand #(
    parameter int DATA_LEN   = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid_in,
    input  logic [DATA_LEN-1:0] key_in,
    output logic                key_ready,
    output logic [DATA_LEN-1:0] round_key,
    output logic                round_key_valid,
    input  logic                round_key_ready,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS);
    localparam logic [7:0] RCON_INIT = 8'h01;

    // AES forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset 8*(255-x); 255-x is simply ~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // GF(2^8) multiply by x, reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic [127:0]   r_round_key;
    logic [3:0]     r_round_idx;
    logic [7:0]     r_rcon;
    logic           r_done;

    logic           w_accept;
    logic           w_advance;
    logic           w_finish;
    logic [127:0]   w_next_key;
    logic [31:0]    w_t;
    logic [31:0]    w_n0;
    logic [31:0]    w_n1;
    logic [31:0]    w_n2;
    logic [31:0]    w_n3;

    // Outputs decoded from state or driven straight from registers.
    assign key_ready       = (r_state == ST_IDLE);
    assign busy            = (r_state == ST_EMIT);
    assign round_key_valid = (r_state == ST_EMIT);
    assign round_key       = r_round_key;
    assign round_idx       = r_round_idx;
    assign done            = r_done;

    // Next round key derived from the current one and the running rcon.
    always_comb begin
        w_t        = sub_word(rot_word(r_round_key[31:0])) ^ {r_rcon, 24'h000000};
        w_n0       = r_round_key[127:96] ^ w_t;
        w_n1       = r_round_key[95:64]  ^ w_n0;
        w_n2       = r_round_key[63:32]  ^ w_n1;
        w_n3       = r_round_key[31:0]   ^ w_n2;
        w_next_key = {w_n0, w_n1, w_n2, w_n3};
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_valid_in) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EMIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (round_key_ready) begin
                    if (r_round_idx == LAST_IDX) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_EMIT;
                    end
                end else begin
                    w_state_next = ST_EMIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round key, index and rcon; all hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_round_key <= 128'h0;
            r_round_idx <= 4'd0;
            r_rcon      <= RCON_INIT;
        end else if (w_accept) begin
            r_round_key <= key_in[127:0];
            r_round_idx <= 4'd0;
            r_rcon      <= RCON_INIT;
        end else if (w_advance) begin
            r_round_key <= w_next_key;
            r_round_idx <= r_round_idx + 4'd1;
            r_rcon      <= xtime(r_rcon);
        end else begin
            r_round_key <= r_round_key;
            r_round_idx <= r_round_idx;
            r_rcon      <= r_rcon;
        end
    end

    // Completion pulse, high for the single cycle after the last handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
        end
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Sequential AES-128 key schedule.
- Accepts one 128-bit cipher key and emits round keys 0..10, one per handshake, each tagged with its round index.
- Sits directly upstream of the AddRoundKey stage and drives its round_key / key_valid_in inputs.
- Computes one round key per cycle from the previous one; does not store all 11 keys.

Parameters:
- DATA_LEN, 128, key and round-key width in bits; only 128 is supported.
- NUM_ROUNDS, 10, index of the last round key emitted; 10 for AES-128.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high.
- key_valid_in  input  1  key_in holds a new cipher key.
- key_in  input  DATA_LEN  cipher key; bits [127:120] are byte 0 (FIPS-197 order).
- key_ready  output  1  high in IDLE; a key is accepted on an edge where key_valid_in && key_ready.
- round_key  output  DATA_LEN  current round key; stable while round_key_valid && !round_key_ready.
- round_key_valid  output  1  round_key / round_idx are valid.
- round_key_ready  input  1  consumer accepts round_key on an edge where round_key_valid && round_key_ready.
- round_idx  output  4  index (0..NUM_ROUNDS) of the round key on round_key.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse after round key NUM_ROUNDS is accepted.

Behaviour:
- Two states, IDLE and EMIT. Both are registered; all outputs are registered or decoded from state.
- Reset values:
  - state = IDLE.
  - key_ready = 1.
  - round_key = 0, round_idx = 0, round_key_valid = 0.
  - busy = 0, done = 0.
  - Internal rcon register = 8'h01.
- IDLE:
  - key_ready = 1, busy = 0, round_key_valid = 0.
  - On an accept edge: round_key <= key_in, round_idx <= 0, rcon <= 8'h01, state <= EMIT.
  - Latency: round key 0 is valid in the first cycle after the accept edge.
- EMIT:
  - key_ready = 0, busy = 1, round_key_valid = 1.
  - On a handshake edge with round_idx < NUM_ROUNDS: round_key <= next key, round_idx <= round_idx + 1, rcon <= xtime(rcon).
  - xtime(x) = (x << 1) ^ (x[7] ? 8'h1B : 0).
  - rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - On a handshake edge with round_idx == NUM_ROUNDS: state <= IDLE, round_key_valid <= 0, done <= 1 for exactly one cycle, key_ready = 1 in that same cycle.
  - round_key and round_idx keep their last values after return to IDLE.
- Next-key computation (combinational from round_key and rcon):
  - Words: w0 = [127:96], w1 = [95:64], w2 = [63:32], w3 = [31:0].
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}. RotWord rotates left by one byte.
  - n0 = w0 ^ t, n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2.
  - SubWord uses four parallel AES S-box lookups (internal function/table).
- Throughput: with round_key_ready held high, 11 consecutive valid cycles, then done.
- Backpressure: round_key_ready low holds round_key, round_idx and rcon unchanged indefinitely.
- key_valid_in while busy: ignored, no effect on state. The key is accepted only once back in IDLE. The upstream holds it per the valid/ready rule.
- key_valid_in high in the done cycle: accepted on that edge (key_ready = 1); the next sequence starts with no gap cycle.
- Reset mid-sequence: all state returns to reset values on that edge; no done pulse; in-flight key discarded.
- reset and key_valid_in high on the same edge: reset wins; key not accepted.
- round_key_ready while round_key_valid = 0: ignored.

Test Plan:
1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, ready held high -> idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx2 = f2c295f27a96b9435935807a7359f67f; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6. 11 consecutive valid cycles, done pulses once in the following cycle.
2. All-zero key -> idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Key 1 as in scenario 1, with round_key_ready low for 3 cycles at idx 4 -> round_key and round_idx = 4 frozen during the stall; remaining keys identical to scenario 1; done only after idx10 handshake.
4. Second key 000102030405060708090a0b0c0d0e0f presented while busy -> not accepted until the done cycle. Its sequence starts back-to-back; idx10 = 13111d7fe3944a17f307a78b4d2b30c5; first key's outputs uncorrupted.
5. reset asserted at idx 6 -> next cycle: round_key_valid = 0, key_ready = 1, round_idx = 0, round_key = 0, no done. A fresh key afterwards reproduces scenario 1 exactly (rcon restarted at 01).
6. Reset and key_valid_in high on the same edge -> key ignored; busy stays 0.
